multicore_mem_arbiter: RTL

Parametrised RAM-port arbiter that connects CPUS cores, each with independent instruction and data request channels, to one shared single-ported RAM. It sits between the per-core cache blocks and the system RAM interface and grants one transaction at a time in round-robin order. It tracks the RAM handshake state and returns wait/load to the granted channel only. A sticky error flag records RAM faults.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/multicore_mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the multicore RAM-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width for n requestors; never below one bit so a lone requestor still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slot index width for a given core count (data + instruction slot per core).
    function automatic int slot_width(input int cpus);
        return idx_width(2 * cpus);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requestor at or after ptr_i, wrapping modulo N.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_oh_o,
    output logic [W-1:0] gnt_idx_o
);

    int p;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        p         = int'(ptr_i);
        // Scan the doubled ring from the top down so the lowest distance from ptr wins last.
        for (int k = 2 * N - 1; k >= 0; k--) begin
            if (k >= p && k < p + N && req_i[k % N]) begin
                gnt_oh_o            = '0;
                gnt_oh_o[k % N]     = 1'b1;
                gnt_idx_o           = W'(k % N);
            end
        end
    end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Connects per-core instruction/data request channels to one shared single-ported RAM, one grant at a time.
module multicore_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][DATA_W-1:0]  iload,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
    input  logic [CPUS-1:0][DATA_W-1:0]  dstore,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][DATA_W-1:0]  dload,
    output logic [ADDR_W-1:0]            ramaddr,
    output logic [DATA_W-1:0]            ramstore,
    output logic                         ramREN,
    output logic                         ramWEN,
    input  logic [DATA_W-1:0]            ramload,
    input  logic [1:0]                   ramstate,
    output logic                         ramerr
);

    localparam int NSLOT  = 2 * CPUS;
    localparam int SLOT_W = slot_width(CPUS);

    arb_state_t        state_q;
    logic [SLOT_W-1:0] ptr_q;
    logic [SLOT_W-1:0] gnt_q;
    logic              ramerr_q;

    logic [NSLOT-1:0]  req;
    logic [NSLOT-1:0]  arb_oh;
    logic [SLOT_W-1:0] arb_idx;
    logic [SLOT_W-1:0] ptr_d;
    logic              gnt_req;
    logic              done;
    ramstate_t         rs;

    assign rs = ramstate_t'(ramstate);

    // Slot 2c is core c's data channel, slot 2c+1 its instruction channel.
    always_comb begin
        req = '0;
        for (int c = 0; c < CPUS; c++) begin
            req[2*c]   = dREN[c] | dWEN[c];
            req[2*c+1] = iREN[c];
        end
    end

    rr_arbiter #(.N(NSLOT)) u_rr (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign ptr_d = (gnt_q == SLOT_W'(NSLOT - 1)) ? '0 : gnt_q + SLOT_W'(1);

    // RAM side follows the granted channel's live inputs, so a dropped request lowers the enables at once.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        gnt_req  = 1'b0;
        if (state_q == GRANT) begin
            for (int c = 0; c < CPUS; c++) begin
                if (gnt_q == SLOT_W'(2 * c)) begin
                    ramaddr  = daddr[c];
                    ramstore = dstore[c];
                    ramWEN   = dWEN[c];
                    ramREN   = dREN[c] & ~dWEN[c];
                    gnt_req  = dREN[c] | dWEN[c];
                end
                if (gnt_q == SLOT_W'(2 * c + 1)) begin
                    ramaddr  = iaddr[c];
                    ramREN   = iREN[c];
                    gnt_req  = iREN[c];
                end
            end
        end
    end

    // A withdrawn request is an abort even if the RAM reports ACCESS in the same cycle.
    assign done = (state_q == GRANT) && gnt_req && (rs == ACCESS);

    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        if (state_q == GRANT) begin
            for (int c = 0; c < CPUS; c++) begin
                if (gnt_q == SLOT_W'(2 * c)) begin
                    dload[c] = ramload;
                    dwait[c] = ~done;
                end
                if (gnt_q == SLOT_W'(2 * c + 1)) begin
                    iload[c] = ramload;
                    iwait[c] = ~done;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous reset in the sensitivity list.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            ramerr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|arb_oh) begin
                        gnt_q   <= arb_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (rs == ERROR) begin
                        ramerr_q <= 1'b1;
                    end
                    if (!gnt_req) begin
                        state_q <= IDLE;
                    end else if (rs == ACCESS) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ramerr = ramerr_q;

endmodule
